// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit CPU: opcodes, ALU codes, bus selects, flag
// indices and the control FSM state set, plus small decode helpers.
package cpu_pkg;

    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_BMI     = 8'h21;
    localparam logic [7:0] OP_BPL     = 8'h22;
    localparam logic [7:0] OP_BEQ     = 8'h23;
    localparam logic [7:0] OP_BNE     = 8'h24;
    localparam logic [7:0] OP_BVS     = 8'h25;
    localparam logic [7:0] OP_BVC     = 8'h26;
    localparam logic [7:0] OP_BCS     = 8'h27;
    localparam logic [7:0] OP_BCC     = 8'h28;
    localparam logic [7:0] OP_ADD_AB  = 8'h42;
    localparam logic [7:0] OP_SUB_AB  = 8'h43;
    localparam logic [7:0] OP_AND_AB  = 8'h44;
    localparam logic [7:0] OP_OR_AB   = 8'h45;
    localparam logic [7:0] OP_INCA    = 8'h46;
    localparam logic [7:0] OP_DECA    = 8'h47;
    localparam logic [7:0] OP_INCB    = 8'h48;
    localparam logic [7:0] OP_DECB    = 8'h49;
    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;
    localparam logic [7:0] OP_HLT     = 8'hFF;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_INCA = 3'b100;
    localparam logic [2:0] ALU_DECA = 3'b101;
    localparam logic [2:0] ALU_INCB = 3'b110;
    localparam logic [2:0] ALU_DECB = 3'b111;

    localparam logic [1:0] BUS1_PC   = 2'b00;
    localparam logic [1:0] BUS1_A    = 2'b01;
    localparam logic [1:0] BUS1_B    = 2'b10;
    localparam logic [1:0] BUS2_ALU  = 2'b00;
    localparam logic [1:0] BUS2_BUS1 = 2'b01;
    localparam logic [1:0] BUS2_MEM  = 2'b10;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [4:0] {
        S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3,
        S_IMM_4, S_IMM_5, S_IMM_6,
        S_DIR_4, S_DIR_5, S_DIR_6, S_DIR_7, S_DIR_8,
        S_ST_4, S_ST_5, S_ST_6, S_ST_7,
        S_ALU_4,
        S_BR_4, S_BR_5, S_BR_6,
        S_BNT_4,
        S_HALT
    } state_t;

    typedef struct packed {
        state_t state;
        logic   br_taken;
    } dbg_t;

    function automatic logic branch_cond(input logic [7:0] op, input logic [3:0] nzvc);
        case (op)
            OP_BRA:  return 1'b1;
            OP_BMI:  return nzvc[FLAG_N];
            OP_BPL:  return !nzvc[FLAG_N];
            OP_BEQ:  return nzvc[FLAG_Z];
            OP_BNE:  return !nzvc[FLAG_Z];
            OP_BVS:  return nzvc[FLAG_V];
            OP_BVC:  return !nzvc[FLAG_V];
            OP_BCS:  return nzvc[FLAG_C];
            OP_BCC:  return !nzvc[FLAG_C];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_code(input logic [7:0] op);
        case (op)
            OP_SUB_AB: return ALU_SUB;
            OP_AND_AB: return ALU_AND;
            OP_OR_AB:  return ALU_OR;
            OP_INCA:   return ALU_INCA;
            OP_DECA:   return ALU_DECA;
            OP_INCB:   return ALU_INCB;
            OP_DECB:   return ALU_DECB;
            default:   return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit boundary: opcode and flags in, data-path strobes out, plus
// a debug view of the FSM state and the branch decision.
interface control_unit_if;
    import cpu_pkg::*;

    logic [7:0] IR;
    logic [3:0] CCR_Result;
    logic       IR_Load;
    logic       MAR_Load;
    logic       PC_Load;
    logic       PC_Inc;
    logic       A_Load;
    logic       B_Load;
    logic       CCR_Load;
    logic [2:0] ALU_Sel;
    logic [1:0] Bus1_Sel;
    logic [1:0] Bus2_Sel;
    logic       write;
    logic       halted;
    dbg_t       dbg;

    modport master (
        output IR, CCR_Result,
        input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
        input  ALU_Sel, Bus1_Sel, Bus2_Sel, write, halted, dbg
    );

    modport slave (
        input  IR, CCR_Result,
        output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
        output ALU_Sel, Bus1_Sel, Bus2_Sel, write, halted, dbg
    );
endinterface

// File: rtl/control_decode.sv
// Maps the fetched opcode and the NZVC flags to the first execute state.
module control_decode
    import cpu_pkg::*;
(
    input  logic [7:0] i_ir,
    input  logic [3:0] i_ccr,
    output state_t     o_entry,
    output logic       o_taken
);
    always_comb begin
        o_entry = S_FETCH_0;
        o_taken = 1'b0;
        case (i_ir)
            OP_LDA_IMM, OP_LDB_IMM: o_entry = S_IMM_4;
            OP_LDA_DIR, OP_LDB_DIR: o_entry = S_DIR_4;
            OP_STA_DIR, OP_STB_DIR: o_entry = S_ST_4;
            OP_ADD_AB, OP_SUB_AB, OP_AND_AB, OP_OR_AB,
            OP_INCA, OP_DECA, OP_INCB, OP_DECB: o_entry = S_ALU_4;
            OP_BRA, OP_BMI, OP_BPL, OP_BEQ, OP_BNE,
            OP_BVS, OP_BVC, OP_BCS, OP_BCC: begin
                o_taken = branch_cond(i_ir, i_ccr);
                o_entry = o_taken ? S_BR_4 : S_BNT_4;
            end
            OP_HLT:  o_entry = S_HALT;
            default: o_entry = S_FETCH_0;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the 8-bit CPU: fetch, decode and execute strobes.
module control_unit
    import cpu_pkg::*;
#(
    parameter int NUM_STATE_BITS = 5
) (
    input  logic           Clk,
    input  logic           Reset,
    control_unit_if.slave  bus
);
    logic [NUM_STATE_BITS-1:0] r_state;
    state_t                    w_state;
    state_t                    w_next;
    state_t                    w_entry;
    logic                      w_taken;
    logic                      w_sel_b;

    assign w_state = state_t'(r_state);
    assign w_sel_b = bus.IR inside {OP_LDB_IMM, OP_LDB_DIR, OP_STB_DIR, OP_INCB, OP_DECB};
    assign bus.dbg = {w_state, w_taken};

    control_decode u_decode (
        .i_ir    (bus.IR),
        .i_ccr   (bus.CCR_Result),
        .o_entry (w_entry),
        .o_taken (w_taken)
    );

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= NUM_STATE_BITS'(S_FETCH_0);
        else       r_state <= NUM_STATE_BITS'(w_next);
    end

    always_comb begin
        w_next = S_FETCH_0;
        case (w_state)
            S_FETCH_0:  w_next = S_FETCH_1;
            S_FETCH_1:  w_next = S_FETCH_2;
            S_FETCH_2:  w_next = S_DECODE_3;
            S_DECODE_3: w_next = w_entry;
            S_IMM_4:    w_next = S_IMM_5;
            S_IMM_5:    w_next = S_IMM_6;
            S_DIR_4:    w_next = S_DIR_5;
            S_DIR_5:    w_next = S_DIR_6;
            S_DIR_6:    w_next = S_DIR_7;
            S_DIR_7:    w_next = S_DIR_8;
            S_ST_4:     w_next = S_ST_5;
            S_ST_5:     w_next = S_ST_6;
            S_ST_6:     w_next = S_ST_7;
            S_BR_4:     w_next = S_BR_5;
            S_BR_5:     w_next = S_BR_6;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_FETCH_0;
        endcase
    end

    // Reset forces every output low regardless of the registered state.
    always_comb begin
        bus.IR_Load  = 1'b0;
        bus.MAR_Load = 1'b0;
        bus.PC_Load  = 1'b0;
        bus.PC_Inc   = 1'b0;
        bus.A_Load   = 1'b0;
        bus.B_Load   = 1'b0;
        bus.CCR_Load = 1'b0;
        bus.ALU_Sel  = ALU_ADD;
        bus.Bus1_Sel = BUS1_PC;
        bus.Bus2_Sel = BUS2_ALU;
        bus.write    = 1'b0;
        bus.halted   = 1'b0;
        if (!Reset) begin
            case (w_state)
                S_FETCH_0, S_IMM_4, S_DIR_4, S_ST_4, S_BR_4: begin
                    bus.Bus1_Sel = BUS1_PC;
                    bus.Bus2_Sel = BUS2_BUS1;
                    bus.MAR_Load = 1'b1;
                end
                S_FETCH_1, S_IMM_5, S_DIR_5, S_ST_5, S_BNT_4: bus.PC_Inc = 1'b1;
                S_FETCH_2: begin
                    bus.Bus2_Sel = BUS2_MEM;
                    bus.IR_Load  = 1'b1;
                end
                S_IMM_6, S_DIR_8: begin
                    bus.Bus2_Sel = BUS2_MEM;
                    bus.A_Load   = !w_sel_b;
                    bus.B_Load   = w_sel_b;
                end
                S_DIR_6, S_ST_6: begin
                    bus.Bus2_Sel = BUS2_MEM;
                    bus.MAR_Load = 1'b1;
                end
                S_ST_7: begin
                    bus.Bus1_Sel = w_sel_b ? BUS1_B : BUS1_A;
                    bus.write    = 1'b1;
                end
                S_ALU_4: begin
                    bus.ALU_Sel  = alu_code(bus.IR);
                    bus.Bus2_Sel = BUS2_ALU;
                    bus.A_Load   = !w_sel_b;
                    bus.B_Load   = w_sel_b;
                    bus.CCR_Load = 1'b1;
                end
                S_BR_6: begin
                    bus.Bus2_Sel = BUS2_MEM;
                    bus.PC_Load  = 1'b1;
                end
                S_HALT:  bus.halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Moore FSM that sequences the 8-bit CPU.
- Fetches the opcode into IR and decodes it, then drives every load, select and increment strobe of the data path, plus the memory write strobe.
- Reads back IR and the NZVC flags to execute loads, stores, ALU ops and branches.
- Sits beside the data path and memory in the CPU top level.

Parameters:
- NUM_STATE_BITS, 5, width of the state register (at least ceil(log2(number of states))).

Ports:
- Clk  input  1  system clock, all state changes on rising edge
- Reset  input  1  synchronous, active-high; state to S_FETCH_0 on next rising edge
- IR  input  8  current opcode from the data path instruction register
- CCR_Result  input  4  flags N=bit3, Z=bit2, V=bit1, C=bit0
- IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load  output  1 each  data-path strobes
- ALU_Sel  output  3  ALU operation code
- Bus1_Sel  output  2  00=PC, 01=A, 10=B
- Bus2_Sel  output  2  00=ALU result, 01=Bus1, 10=from_memory
- write  output  1  memory write strobe; data=Bus1, address=MAR
- halted  output  1  high while in S_HALT

Behaviour:
Reset and outputs:
- While Reset=1, every output is 0.
- On the first Clk edge with Reset=1 the state becomes S_FETCH_0.
- Reset mid-instruction abandons the instruction; no partial write is issued after that edge.
- All outputs are combinational functions of the state and IR only (Moore).
- Any strobe not listed for a state is 0; selects are 00 when unused.

Memory timing:
- Memory is synchronous: data for MAR is valid on from_memory one cycle after MAR loads.

Fetch (all instructions):
- F0: Bus1=PC, Bus2=Bus1, MAR_Load.
- F1: PC_Inc.
- F2: Bus2=mem, IR_Load.
- D3: decode IR, no strobes. The next state is selected by opcode.

Opcodes and execute sequences:
- LDA_IMM 0x86 / LDB_IMM 0x88:
  - E4: MAR<=PC.
  - E5: PC_Inc.
  - E6: Bus2=mem, A_Load or B_Load.
- LDA_DIR 0x87 / LDB_DIR 0x89:
  - E4: MAR<=PC.
  - E5: PC_Inc.
  - E6: Bus2=mem, MAR_Load.
  - E7: wait.
  - E8: Bus2=mem, A_Load or B_Load.
- STA_DIR 0x96 / STB_DIR 0x97:
  - E4: MAR<=PC.
  - E5: PC_Inc.
  - E6: Bus2=mem, MAR_Load.
  - E7: Bus1=A or B, write=1 for exactly one cycle.
- ALU ops, each E4 with Bus2=ALU, A_Load, CCR_Load:
  - ADD_AB 0x42, ALU_Sel=000.
  - SUB_AB 0x43, ALU_Sel=001.
  - AND_AB 0x44, ALU_Sel=010.
  - OR_AB 0x45, ALU_Sel=011.
  - INCA 0x46, ALU_Sel=100.
  - DECA 0x47, ALU_Sel=101.
- INCB 0x48 (ALU_Sel=110) / DECB 0x49 (ALU_Sel=111): as above, but B_Load instead of A_Load.
- BRA 0x20:
  - E4: MAR<=PC.
  - E5: wait.
  - E6: Bus2=mem, PC_Load.
- Conditional branches, taken when the condition is true:
  - BMI 0x21 (N=1), BPL 0x22 (N=0).
  - BEQ 0x23 (Z=1), BNE 0x24 (Z=0).
  - BVS 0x25 (V=1), BVC 0x26 (V=0).
  - BCS 0x27 (C=1), BCC 0x28 (C=0).
  - Taken: same sequence as BRA.
  - Not taken: E4 PC_Inc only, which skips the operand.
- CCR_Result is sampled in D3; a same-cycle CCR change does not alter the decision.
- HLT 0xFF: go to S_HALT. halted=1, no strobes, stays there until Reset.
- Any other opcode is a NOP: D3 returns to F0.

Sequencing and latency:
- The last execute state always returns to F0.
- Cycles per instruction:
  - IMM: 7
  - DIR load: 9
  - store: 8
  - ALU: 5
  - BRA / taken branch: 7
  - branch not taken: 5
- PC wraps 0xFF to 0x00 in the data path; the FSM does not special-case wrap.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants.
  - ALU_Sel codes.
  - Bus1/Bus2 select encodings.
  - NZVC bit indices.
  - state enumeration.
- The data path and ALU consume the same constants.
- One natural sub-module, control_decode: combinational function from IR and CCR_Result to the execute entry state and branch-taken bit.
- The FSM register and output logic remain in control_unit.

Test Plan:
- Reset=1 for 2 cycles, then release:
  - all outputs 0 during reset.
  - the cycle after release has MAR_Load=1, Bus1_Sel=00, Bus2_Sel=01.
- IR=0x86, memory model returns 0xAA:
  - A_Load pulses 6 cycles after F0 with Bus2_Sel=10.
  - PC_Inc pulses twice.
  - total 7 cycles.
- IR=0x96 with operand 0xE0:
  - exactly one write=1 cycle, with Bus1_Sel=01, at cycle 8 of the instruction.
- IR=0x42:
  - one cycle with ALU_Sel=000, Bus2_Sel=00, A_Load=1, CCR_Load=1.
  - next state F0.
- BEQ 0x23:
  - with CCR=0100: PC_Load at E6.
  - with CCR=0000: a single PC_Inc at E4, no PC_Load.
- IR=0xFF:
  - halted=1 held for 20 cycles with all strobes 0.
  - Reset mid-DIR-load (at E7) returns to F0 with no A_Load.
